// File: rtl/lfsr_gen.sv
// Fibonacci/Galois LFSR with seed load, zero-lock protection and period measurement.
// Latency: one cycle from EN/LOAD to Q; no backpressure, EN simply advances one step per cycle.
module lfsr_gen #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] FIB_TAPS = 16'h002D,
  parameter logic [WIDTH-1:0] GAL_TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] SEED     = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] SEED_IN,
  input  logic             GALOIS,
  output logic [WIDTH-1:0] Q,
  output logic             BIT_OUT,
  output logic [WIDTH-1:0] CNT,
  output logic [WIDTH-1:0] PERIOD,
  output logic             PERIOD_DONE,
  output logic             ZERO_SEED
);

  logic [WIDTH-1:0] start_val;
  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_val;
  logic             seed_in_zero;

  always_comb begin
    fib_fb       = ^(Q & FIB_TAPS);
    fib_next     = {fib_fb, Q[WIDTH-1:1]};
    gal_next     = (Q >> 1) ^ (Q[0] ? GAL_TAPS : '0);
    step_next    = GALOIS ? gal_next : fib_next;
    seed_in_zero = (SEED_IN == '0);
    load_val     = seed_in_zero ? SEED : SEED_IN;
  end

  assign BIT_OUT = Q[0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q           <= SEED;
      start_val   <= SEED;
      CNT         <= '0;
      PERIOD      <= '0;
      PERIOD_DONE <= 1'b0;
      ZERO_SEED   <= 1'b0;
    end else begin
      PERIOD_DONE <= 1'b0;
      ZERO_SEED   <= 1'b0;
      if (LOAD) begin
        Q         <= load_val;
        start_val <= load_val;
        CNT       <= '0;
        ZERO_SEED <= seed_in_zero;
      end else if (EN) begin
        if (step_next == '0) begin
          // Lock-up escape: treated as a fresh reseed, so the period restarts from SEED.
          Q         <= SEED;
          start_val <= SEED;
          CNT       <= '0;
          ZERO_SEED <= 1'b1;
        end else if (step_next == start_val) begin
          Q           <= step_next;
          PERIOD      <= CNT + WIDTH'(1);
          CNT         <= '0;
          PERIOD_DONE <= 1'b1;
        end else begin
          Q   <= step_next;
          CNT <= CNT + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: directed vector table, randomized run against a reference model, full-period and 4-bit corner cases.
module tb_lfsr_gen;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- 16-bit DUT with default parameters ----------------
  logic        rst, ld, en, gal;
  logic [15:0] seed;
  logic [15:0] q, cnt, per;
  logic        bo, pd, zs;

  lfsr_gen #(.WIDTH(16), .FIB_TAPS(16'h002D), .GAL_TAPS(16'hB400), .SEED(16'hACE1)) u16 (
    .CLK(CLK), .RESET(rst), .EN(en), .LOAD(ld), .SEED_IN(seed), .GALOIS(gal),
    .Q(q), .BIT_OUT(bo), .CNT(cnt), .PERIOD(per), .PERIOD_DONE(pd), .ZERO_SEED(zs)
  );

  // ---------------- 4-bit maximal DUT ----------------
  logic       rst4, ld4, en4, gal4;
  logic [3:0] seed4, q4, cnt4, per4;
  logic       bo4, pd4, zs4;

  lfsr_gen #(.WIDTH(4), .FIB_TAPS(4'h3), .GAL_TAPS(4'hC), .SEED(4'h1)) u4 (
    .CLK(CLK), .RESET(rst4), .EN(en4), .LOAD(ld4), .SEED_IN(seed4), .GALOIS(gal4),
    .Q(q4), .BIT_OUT(bo4), .CNT(cnt4), .PERIOD(per4), .PERIOD_DONE(pd4), .ZERO_SEED(zs4)
  );

  // ---------------- 4-bit non-maximal DUT that can hit zero ----------------
  logic       rstz, ldz, enz, galz;
  logic [3:0] seedz, qz, cntz, perz;
  logic       boz, pdz, zsz;

  lfsr_gen #(.WIDTH(4), .FIB_TAPS(4'h2), .GAL_TAPS(4'h0), .SEED(4'h5)) uz (
    .CLK(CLK), .RESET(rstz), .EN(enz), .LOAD(ldz), .SEED_IN(seedz), .GALOIS(galz),
    .Q(qz), .BIT_OUT(boz), .CNT(cntz), .PERIOD(perz), .PERIOD_DONE(pdz), .ZERO_SEED(zsz)
  );

  // ---------------- reference model for the 16-bit DUT ----------------
  localparam int unsigned M_FIB  = 32'h002D;
  localparam int unsigned M_GAL  = 32'hB400;
  localparam int unsigned M_SEED = 32'hACE1;

  int unsigned m_q, m_start, m_cnt, m_per;
  bit          m_pd, m_zs;

  function automatic int unsigned ref_step(input int unsigned v, input bit galois);
    int unsigned fb;
    int unsigned r;
    if (galois) begin
      r = v / 2;
      if (v % 2 == 1) r = r ^ M_GAL;
    end else begin
      fb = 0;
      for (int i = 0; i < 16; i++)
        if (((M_FIB >> i) & 1) == 1) fb = fb ^ ((v >> i) & 1);
      r = v / 2 + fb * 32768;
    end
    return r;
  endfunction

  task automatic model_cycle(input bit r, input bit l, input bit e, input bit g, input int unsigned s);
    int unsigned n;
    if (r) begin
      m_q = M_SEED; m_start = M_SEED; m_cnt = 0; m_per = 0; m_pd = 0; m_zs = 0;
    end else begin
      m_pd = 0; m_zs = 0;
      if (l) begin
        m_q = (s == 0) ? M_SEED : s;
        m_start = m_q; m_cnt = 0; m_zs = (s == 0);
      end else if (e) begin
        n = ref_step(m_q, g);
        if (n == 0) begin
          m_q = M_SEED; m_start = M_SEED; m_cnt = 0; m_zs = 1;
        end else if (n == m_start) begin
          m_q = n; m_per = (m_cnt + 1) % 65536; m_cnt = 0; m_pd = 1;
        end else begin
          m_q = n; m_cnt = (m_cnt + 1) % 65536;
        end
      end
    end
  endtask

  typedef struct {
    bit          r, l, e, g;
    logic [15:0] s;
    logic [15:0] eq, ecnt;
    bit          ezs;
    string       nm;
  } vec_t;

  vec_t vecs[12];

  int pulses;
  int pulse_at;
  int zero_hits;

  initial begin
    rst = 1; ld = 0; en = 0; gal = 0; seed = '0;
    rst4 = 1; ld4 = 0; en4 = 0; gal4 = 0; seed4 = '0;
    rstz = 1; ldz = 0; enz = 0; galz = 0; seedz = '0;

    vecs[0]  = '{1, 0, 0, 0, 16'h0000, 16'hACE1, 16'h0000, 0, "reset"};
    vecs[1]  = '{0, 0, 1, 0, 16'h0000, 16'h5670, 16'h0001, 0, "fib_step"};
    vecs[2]  = '{1, 0, 0, 0, 16'h0000, 16'hACE1, 16'h0000, 0, "reset2"};
    vecs[3]  = '{0, 0, 1, 1, 16'h0000, 16'hE270, 16'h0001, 0, "gal_step"};
    vecs[4]  = '{0, 1, 1, 0, 16'h0000, 16'hACE1, 16'h0000, 1, "load_zero"};
    vecs[5]  = '{0, 0, 0, 0, 16'h0000, 16'hACE1, 16'h0000, 0, "hold"};
    vecs[6]  = '{0, 1, 1, 0, 16'h1234, 16'h1234, 16'h0000, 0, "load_beats_en"};
    vecs[7]  = '{1, 1, 1, 0, 16'h5555, 16'hACE1, 16'h0000, 0, "reset_beats_load"};
    vecs[8]  = '{0, 0, 1, 0, 16'h0000, 16'h5670, 16'h0001, 0, "step_after_reset"};
    vecs[9]  = '{0, 1, 0, 0, 16'h0001, 16'h0001, 16'h0000, 0, "load_one"};
    vecs[10] = '{0, 0, 1, 1, 16'h0000, 16'hB400, 16'h0001, 0, "gal_from_one"};
    vecs[11] = '{0, 0, 1, 0, 16'h0000, 16'h5A00, 16'h0002, 0, "fib_after_toggle"};

    tick();
    rst4 = 0; rstz = 0;
    chk("reset_period", {48'h0, per}, 64'h0);
    chk("reset_pd", {63'h0, pd}, 64'h0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; ld = vecs[i].l; en = vecs[i].e; gal = vecs[i].g; seed = vecs[i].s;
      tick();
      chk({vecs[i].nm, "_q"},   {48'h0, q},   {48'h0, vecs[i].eq});
      chk({vecs[i].nm, "_cnt"}, {48'h0, cnt}, {48'h0, vecs[i].ecnt});
      chk({vecs[i].nm, "_zs"},  {63'h0, zs},  {63'h0, vecs[i].ezs});
      chk({vecs[i].nm, "_bit"}, {63'h0, bo},  {63'h0, vecs[i].eq[0]});
    end

    // Randomized run against the model, starting from reset.
    for (int i = 0; i < 3000; i++) begin
      rst  = (i == 0) || ($urandom_range(0, 63) == 0);
      ld   = ($urandom_range(0, 7) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      en   = ($urandom_range(0, 3) != 0);
      gal  = 1'($urandom_range(0, 1));
      model_cycle(rst, ld, en, gal, seed);
      tick();
      chk("rnd_q",   {48'h0, q},   64'(m_q));
      chk("rnd_cnt", {48'h0, cnt}, 64'(m_cnt));
      chk("rnd_per", {48'h0, per}, 64'(m_per));
      chk("rnd_pd",  {63'h0, pd},  64'(m_pd));
      chk("rnd_zs",  {63'h0, zs},  64'(m_zs));
      chk("rnd_bit", {63'h0, bo},  64'(m_q % 2));
    end

    // Full Fibonacci period from SEED.
    rst = 1; ld = 0; en = 0; gal = 0;
    tick();
    rst = 0; en = 1;
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (pd) begin
        pulses++;
        pulse_at = i;
      end
    end
    en = 0;
    chk("full_pulses", 64'(pulses), 64'd1);
    chk("full_pulse_cycle", 64'(pulse_at), 64'd65535);
    chk("full_q", {48'h0, q}, 64'hACE1);
    chk("full_period", {48'h0, per}, 64'hFFFF);
    chk("full_cnt", {48'h0, cnt}, 64'h0);
    tick();
    chk("full_pd_one_cycle", {63'h0, pd}, 64'h0);

    // 4-bit maximal, both modes.
    for (int m = 0; m < 2; m++) begin
      rst4 = 1; gal4 = 1'(m); en4 = 0;
      tick();
      chk("w4_reset_q", {60'h0, q4}, 64'h1);
      rst4 = 0; en4 = 1;
      zero_hits = 0; pulses = 0; pulse_at = 0;
      for (int i = 1; i <= 15; i++) begin
        tick();
        if (q4 == 4'h0) zero_hits++;
        if (pd4) begin
          pulses++;
          pulse_at = i;
        end
      end
      en4 = 0;
      chk(m ? "w4_gal_period" : "w4_fib_period", {60'h0, per4}, 64'd15);
      chk(m ? "w4_gal_zero" : "w4_fib_zero", 64'(zero_hits), 64'd0);
      chk(m ? "w4_gal_pulse" : "w4_fib_pulse", 64'(pulse_at), 64'd15);
      chk(m ? "w4_gal_npulse" : "w4_fib_npulse", 64'(pulses), 64'd1);
    end

    // Non-maximal taps: a step to zero reseeds with SEED=5.
    for (int m = 0; m < 2; m++) begin
      ldz = 1; seedz = 4'h1; enz = 0; galz = 1'(m);
      tick();
      chk("nz_load_q", {60'h0, qz}, 64'h1);
      ldz = 0; enz = 1;
      tick();
      chk(m ? "nz_gal_q" : "nz_fib_q", {60'h0, qz}, 64'h5);
      chk(m ? "nz_gal_zs" : "nz_fib_zs", {63'h0, zsz}, 64'h1);
      chk(m ? "nz_gal_cnt" : "nz_fib_cnt", {60'h0, cntz}, 64'h0);
      enz = 0;
      tick();
      chk("nz_zs_one_cycle", {63'h0, zsz}, 64'h0);
      chk("nz_hold_q", {60'h0, qz}, 64'h5);
    end
    galz = 0; enz = 1;
    tick();
    chk("nz_step_from_seed", {60'h0, qz}, 64'h2);
    chk("nz_cnt_after", {60'h0, cntz}, 64'h1);
    enz = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
- REQ-001: Parameter WIDTH, default 16; register width in bits, legal range 3..64.
- REQ-002: Parameter FIB_TAPS, default 16'h002D; Fibonacci feedback mask, bit i=1 means Q[i] feeds the XOR.
- REQ-003: Parameter GAL_TAPS, default 16'hB400; Galois toggle mask.
- REQ-004: Parameter SEED, default 16'hACE1; value loaded at reset and substituted for a zero seed.
- REQ-005: Port CLK, input, 1; the single clock, all state changes on its rising edge.
- REQ-006: Port RESET, input, 1; synchronous, active-high reset.
- REQ-007: Port EN, input, 1; advance the register one step this cycle.
- REQ-008: Port LOAD, input, 1; load SEED_IN this cycle.
- REQ-009: Port SEED_IN, input, WIDTH; seed value for LOAD.
- REQ-010: Port GALOIS, input, 1; 0 selects Fibonacci stepping, 1 selects Galois stepping.
- REQ-011: Port Q, output, WIDTH; current register state.
- REQ-012: Port BIT_OUT, output, 1; serial output, equal to Q[0].
- REQ-013: Port CNT, output, WIDTH; steps taken since the last load or reset.
- REQ-014: Port PERIOD, output, WIDTH; step count of the last completed cycle.
- REQ-015: Port PERIOD_DONE, output, 1; one-cycle pulse when the state returns to its start value.
- REQ-016: Port ZERO_SEED, output, 1; one-cycle pulse when a zero seed was replaced.

Function
- REQ-017: Control priority per cycle SHALL be RESET, then LOAD, then EN, then hold.
- REQ-018: Fibonacci step SHALL be: fb = XOR of Q[i] over FIB_TAPS[i]=1; Q_next = {fb, Q[WIDTH-1:1]}.
- REQ-019: Galois step SHALL be: Q_next = (Q >> 1) XOR GAL_TAPS if Q[0]=1, else Q >> 1.
- REQ-020: GALOIS SHALL be sampled on every step; a mode change takes effect on the next EN cycle without disturbing Q.
- REQ-021: LOAD SHALL set Q to SEED_IN, or to SEED if SEED_IN is 0.
- REQ-022: LOAD SHALL record the loaded value as the start value.
- REQ-023: LOAD SHALL clear CNT.
- REQ-024: LOAD with SEED_IN=0 SHALL pulse ZERO_SEED in the following cycle.
- REQ-025: EN without LOAD SHALL step Q once.
- REQ-026: EN without LOAD SHALL increment CNT modulo 2^WIDTH.
- REQ-027: When a step yields Q_next equal to the start value, PERIOD_DONE SHALL pulse for exactly one cycle, aligned with Q showing that value.
- REQ-028: When a step yields Q_next equal to the start value, PERIOD SHALL latch CNT+1.
- REQ-029: When a step yields Q_next equal to the start value, CNT SHALL clear to 0.
- REQ-030: Q SHALL never become all-zero. If a step would produce 0 (non-maximal taps), Q SHALL instead load SEED, CNT SHALL clear, and ZERO_SEED SHALL pulse.
- REQ-031: With EN=0 and LOAD=0, Q, CNT and PERIOD SHALL hold, and both pulses SHALL be 0.
- REQ-032: Q, CNT and PERIOD SHALL be registered outputs. BIT_OUT SHALL be a combinational alias of Q[0].

Reset
- REQ-033: RESET high at a rising CLK edge SHALL set Q=SEED, start value=SEED, CNT=0, PERIOD=0, PERIOD_DONE=0 and ZERO_SEED=0, overriding LOAD and EN.
- REQ-034: RESET asserted mid-sequence SHALL discard all progress. The first EN after release SHALL step from SEED.
- REQ-035: No output SHALL depend on RESET combinationally.

Verification
- REQ-036: Reset, then one EN with GALOIS=0 -> Q moves from 16'hACE1 to 16'h5670, CNT=1, BIT_OUT 1 to 0.
- REQ-037: Reset, then one EN with GALOIS=1 -> Q=16'hE270, CNT=1.
- REQ-038: Reset, then EN held for 65535 cycles in either mode -> PERIOD_DONE pulses once on cycle 65535, Q=16'hACE1, PERIOD=16'hFFFF, CNT=0.
- REQ-039: LOAD with SEED_IN=0 -> Q=16'hACE1, ZERO_SEED pulses one cycle, CNT=0. LOAD and EN together -> load wins and no step occurs.
- REQ-040: RESET and LOAD=1 with EN=1 in the same cycle -> Q=16'hACE1, CNT=0. Toggle GALOIS between steps -> each step matches the reference model for the sampled mode.
- REQ-041: WIDTH=4, FIB_TAPS=4'h3, SEED=4'h1, EN held -> PERIOD=15 and the all-zero state is never reached. Non-maximal taps reaching 0 -> Q reloads SEED and ZERO_SEED pulses.
